nand_phy_async_seq: RTL and testbench

//  Cycle-timed asynchronous (legacy WE#/RE#) NAND bus sequencer for the PHY layer; successor to the fixed x8/2-CE PHY path.

---
 rtl/nand_phy_async_seq.sv | 217 +++++++++++++++++++++
 tb/tb_nand_phy_async_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/nand_phy_async_seq.sv
// nand_phy_async_seq: legacy async (WE#/RE#) NAND bus sequencer, one CMD/ADDR/WRITE/READ op at a time; optional R/B# wait via NAND_ASYNC_RB_WAIT_EN.
// Latency: accept-to-accept T_SETUP+T_WP+T_WH cycles (+T_CEH on a CE change); rsp_valid T_SETUP+T_WP cycles after accept.
// Backpressure: req_ready low while an op owns the bus (high again in its final strobe-high cycle, in CE_HOLD and in IDLE).
module nand_phy_async_seq #(
   parameter int DQ_WIDTH = 8,
   parameter int NUM_CE   = 2,
   parameter int T_SETUP  = 2,
   parameter int T_WP     = 3,
   parameter int T_WH     = 2,
   parameter int T_CEH    = 4,
   parameter int CE_IDLE  = 16
) (
   input  logic                v_clk0,
   input  logic                v_rst0,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [1:0]          req_op,
   input  logic [DQ_WIDTH-1:0] req_data,
   input  logic [NUM_CE-1:0]   req_ce,
`ifdef NAND_ASYNC_RB_WAIT_EN
   input  logic                req_wait_rb,
   input  logic [NUM_CE-1:0]   v_rb_n,
`endif
   output logic                rsp_valid,
   output logic [DQ_WIDTH-1:0] rsp_data,
   output logic                v_cle,
   output logic                v_ale,
   output logic                v_wen,
   output logic                v_ren,
   output logic [NUM_CE-1:0]   v_cen,
   output logic [DQ_WIDTH-1:0] v_dq_out,
   output logic                v_dq_oe_n,
   input  logic [DQ_WIDTH-1:0] v_dq_in
);

   localparam logic [1:0] OP_CMD  = 2'b00;
   localparam logic [1:0] OP_ADDR = 2'b01;
   localparam logic [1:0] OP_READ = 2'b11;

   // Phase reloads hold (cycles - 1); zero-length phases are stretched to one cycle.
   localparam logic [3:0] SETUP_M1 = (T_SETUP < 2) ? 4'd0 : 4'(T_SETUP - 1);
   localparam logic [3:0] WP_M1    = (T_WP    < 2) ? 4'd0 : 4'(T_WP - 1);
   localparam logic [3:0] WH_M1    = (T_WH    < 2) ? 4'd0 : 4'(T_WH - 1);
   localparam logic [3:0] CEH_M1   = (T_CEH   < 2) ? 4'd0 : 4'(T_CEH - 1);
   localparam logic [7:0] IDLE_M1  = (CE_IDLE < 2) ? 8'd0 : 8'(CE_IDLE - 1);

   typedef enum logic [2:0] {
      IDLE, CE_SW, SETUP, STRB_LO, STRB_HI, CE_HOLD
`ifdef NAND_ASYNC_RB_WAIT_EN
      , WAIT_RB
`endif
   } state_t;

   state_t                state_q, state_d, accept_tgt;
   logic [3:0]            phase_q;
   logic [7:0]            idle_q;
   logic [1:0]            op_q, op_n;
   logic [DQ_WIDTH-1:0]   data_q, data_n;
   logic [NUM_CE-1:0]     mask_q, mask_n;
   logic                  phase_last, accept, wait_sel, rd_capture;
   logic                  cle_d, ale_d, wen_d, ren_d, oe_n_d;
   logic [NUM_CE-1:0]     cen_d;
   logic [DQ_WIDTH-1:0]   dq_d;

   function automatic logic [3:0] phase_len(input state_t s);
      case (s)
         CE_SW:   return CEH_M1;
         SETUP:   return SETUP_M1;
         STRB_LO: return WP_M1;
         STRB_HI: return WH_M1;
         default: return 4'd0;
      endcase
   endfunction

   assign phase_last = (phase_q == 4'd0);
   assign accept     = req_valid & req_ready;
   assign op_n       = accept ? req_op   : op_q;
   assign data_n     = accept ? req_data : data_q;
   assign mask_n     = accept ? req_ce   : mask_q;
   assign rd_capture = (state_q == STRB_LO) && phase_last && (op_q == OP_READ);
   // Same mask, or nothing asserted yet: no CE# gap is needed before the new op.
   assign accept_tgt = ((req_ce == ~v_cen) || (&v_cen)) ? SETUP : CE_SW;

`ifdef NAND_ASYNC_RB_WAIT_EN
   logic [NUM_CE-1:0] rb_meta, rb_sync;
   logic              rb_ok, rb_ok_q, wait_q;

   assign rb_ok    = &(rb_sync | ~mask_q);
   assign wait_sel = wait_q;

   // Two-flop R/B# synchroniser plus one cycle of ready history and the latched wait request.
   always_ff @(posedge v_clk0 or posedge v_rst0) begin
      if (v_rst0) begin
         rb_meta <= '1;
         rb_sync <= '1;
         rb_ok_q <= 1'b0;
         wait_q  <= 1'b0;
      end else begin
         rb_meta <= v_rb_n;
         rb_sync <= rb_meta;
         rb_ok_q <= rb_ok;
         if (accept) wait_q <= req_wait_rb;
      end
   end
`else
   assign wait_sel = 1'b0;
`endif

   // Ready in idle/hold, and in the last strobe-high cycle so same-CE ops run back to back.
   always_comb begin
      req_ready = 1'b0;
      case (state_q)
         IDLE, CE_HOLD: req_ready = 1'b1;
         STRB_HI:       req_ready = phase_last & ~wait_sel;
         default:       req_ready = 1'b0;
      endcase
   end

   // State, phase counter, CE idle timer and latched request.
   always_ff @(posedge v_clk0 or posedge v_rst0) begin
      if (v_rst0) begin
         state_q <= IDLE;
         phase_q <= 4'd0;
         idle_q  <= 8'd0;
         op_q    <= 2'b00;
         data_q  <= '0;
         mask_q  <= '0;
      end else begin
         state_q <= state_d;
         if (state_d != state_q)  phase_q <= phase_len(state_d);
         else if (!phase_last)    phase_q <= phase_q - 4'd1;
         idle_q  <= (state_q == CE_HOLD && state_d == CE_HOLD) ? idle_q + 8'd1 : 8'd0;
         op_q    <= op_n;
         data_q  <= data_n;
         mask_q  <= mask_n;
      end
   end

   // Next-state sequencing through the bus phases.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = accept_tgt;
         CE_SW:   if (phase_last) state_d = SETUP;
         SETUP:   if (phase_last) state_d = STRB_LO;
         STRB_LO: if (phase_last) state_d = STRB_HI;
         STRB_HI: begin
            if (accept)          state_d = accept_tgt;
`ifdef NAND_ASYNC_RB_WAIT_EN
            else if (phase_last) state_d = wait_sel ? WAIT_RB : CE_HOLD;
`else
            else if (phase_last) state_d = CE_HOLD;
`endif
         end
         CE_HOLD: begin
            if (accept)                 state_d = accept_tgt;
            else if (idle_q == IDLE_M1) state_d = IDLE;
         end
`ifdef NAND_ASYNC_RB_WAIT_EN
         WAIT_RB: if (rb_ok && rb_ok_q) state_d = CE_HOLD;
`endif
         default: state_d = IDLE;
      endcase
   end

   // Bus pin values for the state being entered; registered below so pins change with the state.
   always_comb begin
      cle_d  = 1'b0;
      ale_d  = 1'b0;
      wen_d  = 1'b1;
      ren_d  = 1'b1;
      oe_n_d = 1'b1;
      cen_d  = v_cen;
      dq_d   = v_dq_out;
      case (state_d)
         IDLE, CE_SW: cen_d = '1;
         SETUP, STRB_LO, STRB_HI: begin
            cen_d  = ~mask_n;
            cle_d  = (op_n == OP_CMD);
            ale_d  = (op_n == OP_ADDR);
            oe_n_d = (op_n == OP_READ);
            if (op_n != OP_READ) dq_d = data_n;
            if (state_d == STRB_LO) begin
               if (op_n == OP_READ) ren_d = 1'b0;
               else                 wen_d = 1'b0;
            end
         end
         default: cen_d = v_cen;
      endcase
   end

   // Registered NAND pins and read response.
   always_ff @(posedge v_clk0 or posedge v_rst0) begin
      if (v_rst0) begin
         v_cle     <= 1'b0;
         v_ale     <= 1'b0;
         v_wen     <= 1'b1;
         v_ren     <= 1'b1;
         v_cen     <= '1;
         v_dq_out  <= '0;
         v_dq_oe_n <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
      end else begin
         v_cle     <= cle_d;
         v_ale     <= ale_d;
         v_wen     <= wen_d;
         v_ren     <= ren_d;
         v_cen     <= cen_d;
         v_dq_out  <= dq_d;
         v_dq_oe_n <= oe_n_d;
         rsp_valid <= rd_capture;
         if (rd_capture) rsp_data <= v_dq_in;
      end
   end

endmodule

// File: tb/tb_nand_phy_async_seq.sv
// tb_nand_phy_async_seq: random op stream against a phase-arithmetic timing model.
// Latency: n/a (testbench).
// Backpressure: bench holds req_valid until the model predicts acceptance, sometimes dropping it.
module tb_nand_phy_async_seq;
   localparam int TS = 2, TWP = 3, TWH = 2, TCEH = 4, CEI = 16;
   localparam int OPLEN = TS + TWP + TWH;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [1:0] req_op = 2'b00;
   logic [7:0] req_data = 8'h00;
   logic [1:0] req_ce = 2'b00;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       cle, ale, wen, ren, dq_oe_n;
   logic [1:0] cen;
   logic [7:0] dq_out;
   logic [7:0] dq_in = 8'h00;

   always #5 clk = ~clk;

   nand_phy_async_seq dut (
      .v_clk0(clk), .v_rst0(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_data(req_data), .req_ce(req_ce),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data),
      .v_cle(cle), .v_ale(ale), .v_wen(wen), .v_ren(ren), .v_cen(cen),
      .v_dq_out(dq_out), .v_dq_oe_n(dq_oe_n), .v_dq_in(dq_in)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference model: the last accepted op and the cycle its bus phases start.
   bit         has_op = 0;
   int         a_cyc = 0, s_cyc = 0;
   logic [1:0] m_op = 2'b00, m_mask = 2'b00;
   logic [7:0] m_data = 8'h00, m_rsp = 8'h00;
   bit         m_sw = 0;
   int         cyc = 0;
   int         mode = 0;
   bit         just_acc = 0;
   bit         reached = 0;
   logic [7:0] dq_hist [0:8191];

   typedef struct packed {
      logic       cle, ale, wen, ren;
      logic [1:0] cen;
      logic       oe_n, ready, rsp_vld;
   } exp_t;

   function automatic exp_t model_at(input int k);
      exp_t x;
      int d, e;
      x.cle = 0; x.ale = 0; x.wen = 1; x.ren = 1; x.cen = 2'b11;
      x.oe_n = 1; x.ready = 1; x.rsp_vld = 0;
      if (has_op) begin
         d = k - a_cyc;
         e = k - s_cyc;
         if (m_sw && d < TCEH) begin
            x.ready = 0;
         end else if (e < OPLEN) begin
            x.cen   = ~m_mask;
            x.cle   = (m_op == 2'd0);
            x.ale   = (m_op == 2'd1);
            x.oe_n  = (m_op == 2'd3);
            if (e >= TS && e < TS + TWP) begin
               if (m_op == 2'd3) x.ren = 0;
               else              x.wen = 0;
            end
            x.rsp_vld = (m_op == 2'd3) && (e == TS + TWP);
            x.ready   = (e == OPLEN - 1);
         end else begin
            x.cen = (e - OPLEN < CEI) ? ~m_mask : 2'b11;
         end
      end
      return x;
   endfunction

   function automatic logic [1:0] pick_ce();
      case ($urandom_range(7))
         0, 1, 2, 3: return 2'b01;
         4, 6:       return 2'b10;
         5:          return 2'b11;
         default:    return 2'b00;
      endcase
   endfunction

   // One clock: check outputs of cycle cyc, then drive inputs for the next edge.
   task automatic step();
      exp_t x;
      bit   sw;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      x = model_at(cyc);
      if (x.rsp_vld) m_rsp = dq_hist[s_cyc + TS + TWP - 1];
      check_val("cle", cle, x.cle);
      check_val("ale", ale, x.ale);
      check_val("wen", wen, x.wen);
      check_val("ren", ren, x.ren);
      check_val("cen", cen, x.cen);
      check_val("dq_oe_n", dq_oe_n, x.oe_n);
      check_val("req_ready", req_ready, x.ready);
      check_val("rsp_valid", rsp_valid, x.rsp_vld);
      check_val("rsp_data", rsp_data, m_rsp);
      if (!x.oe_n) check_val("dq_out", dq_out, m_data);

      dq_in = 8'($urandom_range(255));
      dq_hist[cyc] = dq_in;
      if (mode == 0) begin
         if (just_acc || !req_valid) begin
            req_valid = ($urandom_range(99) < 55);
            req_op    = 2'($urandom_range(3));
            req_data  = 8'($urandom_range(255));
            req_ce    = req_valid ? pick_ce() : 2'($urandom_range(3));
         end else if ($urandom_range(99) < 8) begin
            req_valid = 0;
         end
      end else if (mode == 2) begin
         req_valid = 1; req_op = 2'd3; req_ce = 2'b01; req_data = 8'h5A;
      end else begin
         req_valid = 0;
      end

      just_acc = 0;
      if (req_valid && x.ready) begin
         sw       = (x.cen != 2'b11) && (~x.cen != req_ce);
         has_op   = 1;
         a_cyc    = cyc + 1;
         m_sw     = sw;
         s_cyc    = a_cyc + (sw ? TCEH : 0);
         m_op     = req_op;
         m_data   = req_data;
         m_mask   = req_ce;
         just_acc = 1;
         if (mode == 2) mode = 1;
      end
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_val("rst_cle", cle, 0);
      check_val("rst_ale", ale, 0);
      check_val("rst_wen", wen, 1);
      check_val("rst_ren", ren, 1);
      check_val("rst_cen", cen, 2'b11);
      check_val("rst_dq_out", dq_out, 0);
      check_val("rst_dq_oe_n", dq_oe_n, 1);
      check_val("rst_req_ready", req_ready, 1);
      check_val("rst_rsp_valid", rsp_valid, 0);
      check_val("rst_rsp_data", rsp_data, 0);
      rst = 0;
      cyc = 0;

      mode = 0;
      repeat (3000) step();

      // Drain to idle, then reset in the middle of a READ strobe.
      mode = 1;
      repeat (40) step();
      mode = 2;
      reached = 0;
      for (int i = 0; i < 60 && !reached; i++) begin
         step();
         reached = has_op && (m_op == 2'd3) && ((cyc - s_cyc) == TS + 1);
      end
      check_val("rst_mid_reach", reached, 1);
      check_val("rst_mid_ren_pre", ren, 0);
      #2 rst = 1;
      #1;
      check_val("rst_mid_wen", wen, 1);
      check_val("rst_mid_ren", ren, 1);
      check_val("rst_mid_cen", cen, 2'b11);
      check_val("rst_mid_ready", req_ready, 1);
      check_val("rst_mid_rsp_valid", rsp_valid, 0);
      check_val("rst_mid_oe_n", dq_oe_n, 1);
      has_op = 0; m_rsp = 8'h00; just_acc = 0; req_valid = 0; mode = 1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 0;
      repeat (20) step();

      mode = 0;
      repeat (400) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
